// File: rtl/mem_access_seq_if.sv
// Request/response and byte-wide RAM controller signals of the load/store sequencer.
// slave: the sequencer's view; master: the requester/RAM side.
interface mem_access_seq_if;
  logic        req_valid;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        busy;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_addr;
  logic [7:0]  mem_w_data;
  logic [7:0]  mem_r_data;
  logic        mem_done;

  modport slave (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    input  mem_r_data, mem_done,
    output busy, resp_valid, resp_rdata,
    output mem_read, mem_write, mem_addr, mem_w_data
  );

  modport master (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    output mem_r_data, mem_done,
    input  busy, resp_valid, resp_rdata,
    input  mem_read, mem_write, mem_addr, mem_w_data
  );
endinterface

// File: rtl/mem_access_seq.sv
// Splits a byte/half/word load or store into sequential byte accesses on a
// byte-wide RAM port, assembling and extending load data little-endian.
module mem_access_seq (
  input  logic            clk_in,
  input  logic            rst_in,
  mem_access_seq_if.slave bus
);

  typedef enum logic [1:0] {IDLE, XFER, CAPTURE, RESP} state_e;

  state_e          state_q, state_d;
  logic [1:0]      idx_q, idx_d;
  logic [2:0]      byte_cnt_q, byte_cnt_d;
  logic            we_q, we_d;
  logic [1:0]      size_q, size_d;
  logic            uns_q, uns_d;
  logic [31:0]     addr_q, addr_d;
  logic [3:0][7:0] wdata_q, wdata_d;
  logic [3:0][7:0] data_q, data_d;
  logic            cap_pend_q, cap_pend_d;
  logic [1:0]      cap_lane_q, cap_lane_d;

  logic            busy_q, busy_d;
  logic            resp_valid_q, resp_valid_d;
  logic [31:0]     resp_rdata_q, resp_rdata_d;
  logic            mem_read_q, mem_read_d;
  logic            mem_write_q, mem_write_d;
  logic [31:0]     mem_addr_q, mem_addr_d;
  logic [7:0]      mem_w_data_q, mem_w_data_d;

  function automatic logic [31:0] extend(input logic [3:0][7:0] d,
                                         input logic [1:0] sz,
                                         input logic uns);
    logic [31:0] r;
    case (sz)
      2'b00:   r = {{24{~uns & d[0][7]}}, d[0]};
      2'b01:   r = {{16{~uns & d[1][7]}}, d[1], d[0]};
      default: r = d;
    endcase
    return r;
  endfunction

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    byte_cnt_d   = byte_cnt_q;
    we_d         = we_q;
    size_d       = size_q;
    uns_d        = uns_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    data_d       = data_q;
    cap_pend_d   = 1'b0;
    cap_lane_d   = cap_lane_q;
    resp_rdata_d = '0;

    // RAM returns read data one cycle after the acknowledge, so the lane
    // of each acknowledged byte is carried forward one cycle.
    if (cap_pend_q) begin
      data_d[cap_lane_q] = bus.mem_r_data;
    end

    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          we_d       = bus.req_we;
          size_d     = bus.req_size;
          uns_d      = bus.req_unsigned;
          addr_d     = bus.req_addr;
          wdata_d    = bus.req_wdata;
          byte_cnt_d = (bus.req_size == 2'b00) ? 3'd1 :
                       (bus.req_size == 2'b01) ? 3'd2 : 3'd4;
          idx_d      = '0;
          data_d     = '0;
          state_d    = XFER;
        end
      end
      XFER: begin
        if (bus.mem_done) begin
          cap_pend_d = ~we_q;
          cap_lane_d = idx_q;
          if ({1'b0, idx_q} == byte_cnt_q - 3'd1) begin
            state_d = we_q ? RESP : CAPTURE;
          end else begin
            idx_d = idx_q + 2'd1;
          end
        end
      end
      CAPTURE: begin
        state_d      = RESP;
        resp_rdata_d = extend(data_d, size_q, uns_q);
      end
      RESP: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Outputs are precomputed from the next state so they leave flops directly.
    busy_d       = (state_d != IDLE);
    resp_valid_d = (state_d == RESP);
    mem_read_d   = (state_d == XFER) && !we_d;
    mem_write_d  = (state_d == XFER) && we_d;
    mem_addr_d   = (state_d == XFER) ? addr_d + {30'b0, idx_d} : '0;
    mem_w_data_d = ((state_d == XFER) && we_d) ? wdata_d[idx_d] : '0;
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      byte_cnt_q   <= '0;
      we_q         <= 1'b0;
      size_q       <= '0;
      uns_q        <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      data_q       <= '0;
      cap_pend_q   <= 1'b0;
      cap_lane_q   <= '0;
      busy_q       <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      mem_addr_q   <= '0;
      mem_w_data_q <= '0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      byte_cnt_q   <= byte_cnt_d;
      we_q         <= we_d;
      size_q       <= size_d;
      uns_q        <= uns_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      data_q       <= data_d;
      cap_pend_q   <= cap_pend_d;
      cap_lane_q   <= cap_lane_d;
      busy_q       <= busy_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      mem_read_q   <= mem_read_d;
      mem_write_q  <= mem_write_d;
      mem_addr_q   <= mem_addr_d;
      mem_w_data_q <= mem_w_data_d;
    end
  end

  assign bus.busy       = busy_q;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_rdata = resp_rdata_q;
  assign bus.mem_read   = mem_read_q;
  assign bus.mem_write  = mem_write_q;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_w_data = mem_w_data_q;

endmodule
